// File: rtl/prefix_scan_pipe.sv
// Pipelined Kogge-Stone prefix/suffix scan (AND/OR/XOR, inclusive/exclusive)
// with an elastic valid/ready pipeline carrying a tag alongside each vector.
module prefix_scan_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic [1:0]       in_op,
  input  logic             in_suffix,
  input  logic             in_excl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] rdy;
  logic [STAGES:0]   src_v;
  logic              rdy_acc;

  logic [WIDTH-1:0]  d_q     [STAGES];
  logic [1:0]        op_q    [STAGES];
  logic              suf_q   [STAGES];
  logic              excl_q  [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];

  logic [WIDTH-1:0]  src_d    [STAGES];
  logic [1:0]        src_op   [STAGES];
  logic              src_suf  [STAGES];
  logic              src_excl [STAGES];
  logic [TAG_W-1:0]  src_tag  [STAGES];
  logic [WIDTH-1:0]  nxt_d    [STAGES];

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    for (int i = 0; i < WIDTH; i++) y[i] = x[WIDTH-1-i];
    return y;
  endfunction

  function automatic logic combine(input logic [1:0] op, input logic a, input logic b);
    logic y;
    case (op)
      2'd1:    y = a | b;
      2'd2:    y = a ^ b;
      default: y = a & b;
    endcase
    return y;
  endfunction

  // Applies exactly the Kogge-Stone levels that belong to stage s.
  function automatic logic [WIDTH-1:0] run_stage(input logic [WIDTH-1:0] x,
                                                 input logic [1:0] op, input int s);
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    cur = x;
    for (int k = 0; k < LEVELS; k++) begin
      if ((k * STAGES) / LEVELS == s) begin
        nxt = cur;
        for (int i = 0; i < WIDTH; i++)
          if (i >= (1 << k)) nxt[i] = combine(op, cur[i], cur[i - (1 << k)]);
        cur = nxt;
      end
    end
    return cur;
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input logic [WIDTH-1:0] x, input logic [1:0] op,
                                                input logic suf, input logic excl);
    logic [WIDTH-1:0] y;
    logic             ident;
    ident = !(op == 2'd1 || op == 2'd2);
    y = excl ? {x[WIDTH-2:0], ident} : x;
    return suf ? bitrev(y) : y;
  endfunction

  // Ready ripples back from the output: a stage accepts if it or anything downstream has room.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy_acc = !v_q[s] || rdy_acc;
      rdy[s]  = rdy_acc;
    end
  end

  assign src_v = {v_q, in_valid};

  always_comb begin
    src_d[0]    = in_suffix ? bitrev(in_vec) : in_vec;
    src_op[0]   = in_op;
    src_suf[0]  = in_suffix;
    src_excl[0] = in_excl;
    src_tag[0]  = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      src_d[s]    = d_q[s-1];
      src_op[s]   = op_q[s-1];
      src_suf[s]  = suf_q[s-1];
      src_excl[s] = excl_q[s-1];
      src_tag[s]  = tag_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      nxt_d[s] = run_stage(src_d[s], src_op[s], s);
      if (s == STAGES - 1)
        nxt_d[s] = finalize(nxt_d[s], src_op[s], src_suf[s], src_excl[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      v_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++)
        if (rdy[s]) v_q[s] <= src_v[s];
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (rdy[s] && src_v[s]) begin
        d_q[s]    <= nxt_d[s];
        op_q[s]   <= src_op[s];
        suf_q[s]  <= src_suf[s];
        excl_q[s] <= src_excl[s];
        tag_q[s]  <= src_tag[s];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign out_vec   = d_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_prefix_scan_pipe.sv
// Directed and random bench for prefix_scan_pipe across WIDTH 2/8/32 and STAGES 1/3.
module tb_prefix_scan_pipe;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, out_ready, suffix, excl;
  logic [1:0]  op;
  logic [31:0] vec;
  logic [3:0]  tag;

  logic r1, v1, r3, v3, r2, v2, r32, v32;
  logic [7:0]  o1, o3;
  logic [1:0]  o2;
  logic [31:0] o32;
  logic [3:0]  t1, t3, t2, t32;

  int checks = 0;
  int errors = 0;

  logic [35:0] bq[$];
  logic [35:0] sb [3][$];
  logic        rv [3];
  logic        vv [3];
  logic [31:0] ov [3];
  logic [3:0]  tv [3];

  always #5 clk = ~clk;

  prefix_scan_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) d1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_vec(vec[7:0]), .in_op(op), .in_suffix(suffix), .in_excl(excl), .in_tag(tag),
    .out_valid(v1), .out_ready(out_ready), .out_vec(o1), .out_tag(t1));

  prefix_scan_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(4)) d3 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(r3),
    .in_vec(vec[7:0]), .in_op(op), .in_suffix(suffix), .in_excl(excl), .in_tag(tag),
    .out_valid(v3), .out_ready(out_ready), .out_vec(o3), .out_tag(t3));

  prefix_scan_pipe #(.WIDTH(2), .STAGES(1), .TAG_W(4)) d2 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(r2),
    .in_vec(vec[1:0]), .in_op(op), .in_suffix(suffix), .in_excl(excl), .in_tag(tag),
    .out_valid(v2), .out_ready(out_ready), .out_vec(o2), .out_tag(t2));

  prefix_scan_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(4)) d32 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_vec(vec), .in_op(op), .in_suffix(suffix), .in_excl(excl), .in_tag(tag),
    .out_valid(v32), .out_ready(out_ready), .out_vec(o32), .out_tag(t32));

  assign rv[0] = r2;  assign vv[0] = v2;  assign ov[0] = {30'b0, o2}; assign tv[0] = t2;
  assign rv[1] = r3;  assign vv[1] = v3;  assign ov[1] = {24'b0, o3}; assign tv[1] = t3;
  assign rv[2] = r32; assign vv[2] = v32; assign ov[2] = o32;         assign tv[2] = t32;

  // Straightforward range fold, deliberately unrelated to the log-depth structure.
  function automatic logic [31:0] ref_scan(input logic [31:0] x, input int w, input logic [1:0] o,
                                           input logic sf, input logic ex);
    logic [31:0] y;
    logic        acc;
    logic        inr;
    y = '0;
    for (int i = 0; i < w; i++) begin
      acc = (o == 2'd1 || o == 2'd2) ? 1'b0 : 1'b1;
      for (int j = 0; j < w; j++) begin
        if (sf) inr = ex ? (j > i) : (j >= i);
        else    inr = ex ? (j < i) : (j <= i);
        if (inr) begin
          case (o)
            2'd1:    acc = acc | x[j];
            2'd2:    acc = acc ^ x[j];
            default: acc = acc & x[j];
          endcase
        end
      end
      y[i] = acc;
    end
    return y;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    vec = '0; op = 2'd0; suffix = 1'b0; excl = 1'b0; tag = '0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (v1 !== 1'b0)  begin errors++; $display("FAIL reset_v1: got %b want 0", v1); end
    checks++; if (r1 !== 1'b1)  begin errors++; $display("FAIL reset_r1: got %b want 1", r1); end
    checks++; if (v3 !== 1'b0)  begin errors++; $display("FAIL reset_v3: got %b want 0", v3); end
    checks++; if (r3 !== 1'b1)  begin errors++; $display("FAIL reset_r3: got %b want 1", r3); end
    checks++; if (v2 !== 1'b0)  begin errors++; $display("FAIL reset_v2: got %b want 0", v2); end
    checks++; if (v32 !== 1'b0) begin errors++; $display("FAIL reset_v32: got %b want 0", v32); end
    checks++; if (r32 !== 1'b1) begin errors++; $display("FAIL reset_r32: got %b want 1", r32); end
  endtask

  task automatic test_vectors();
    logic [7:0] dv [12];
    logic [1:0] dop [12];
    logic       dsf [12];
    logic       dex [12];
    logic [7:0] dexp [12];
    dv   = '{8'hEF, 8'h14, 8'h14, 8'h07, 8'hFF, 8'hEF, 8'h07, 8'h14, 8'hF7, 8'h81, 8'h00, 8'h80};
    dop  = '{2'd0,  2'd1,  2'd1,  2'd2,  2'd0,  2'd3,  2'd2,  2'd1,  2'd0,  2'd2,  2'd0,  2'd2};
    dsf  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    dex  = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    dexp = '{8'hE0, 8'hFC, 8'hF8, 8'hFA, 8'hFF, 8'hE0, 8'h05, 8'h0F, 8'h07, 8'h7F, 8'h01, 8'h7F};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      vec = {24'b0, dv[i]}; op = dop[i]; suffix = dsf[i]; excl = dex[i]; tag = 4'(i);
      #1;
      checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL vec_ready[%0d]: got %b want 1", i, r1); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (v1 !== 1'b1 || o1 !== dexp[i] || t1 !== 4'(i)) begin
        errors++;
        $display("FAIL vec[%0d]: got v=%b vec=%h tag=%h want v=1 vec=%h tag=%h",
                 i, v1, o1, t1, dexp[i], 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int          sent, recv, cyc;
    logic        held;
    logic [7:0]  held_vec;
    logic [3:0]  held_tag;
    logic [31:0] e;
    logic [35:0] ent;
    do_flush();
    bq.delete();
    sent = 0; recv = 0; cyc = 0; held = 1'b0; held_vec = '0; held_tag = '0;
    while (recv < 20 && cyc < 300) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 20) begin
        in_valid = 1'b1;
        vec = {24'b0, 8'(sent * 37 + 11)};
        op = 2'(sent % 4); suffix = sent[1]; excl = sent[2]; tag = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checks++;
        if (v3 !== 1'b1 || o3 !== held_vec || t3 !== held_tag) begin
          errors++;
          $display("FAIL b2b_stall: got v=%b vec=%h tag=%h want v=1 vec=%h tag=%h",
                   v3, o3, t3, held_vec, held_tag);
        end
      end
      checks++;
      if (r3 !== ((bq.size() < 3) || out_ready)) begin
        errors++;
        $display("FAIL b2b_ready: got %b want %b (held=%0d)", r3, (bq.size() < 3) || out_ready, bq.size());
      end
      if (v3 === 1'b1 && out_ready) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got tag=%h want no output", t3);
        end else begin
          ent = bq.pop_front();
          if (o3 !== ent[7:0] || t3 !== ent[35:32]) begin
            errors++;
            $display("FAIL b2b_out[%0d]: got vec=%h tag=%h want vec=%h tag=%h",
                     recv, o3, t3, ent[7:0], ent[35:32]);
          end
        end
        recv++;
      end
      if (in_valid && r3 === 1'b1) begin
        e = ref_scan(vec, 8, op, suffix, excl);
        bq.push_back({tag, e});
        sent++;
      end
      held = (v3 === 1'b1) && !out_ready;
      held_vec = o3; held_tag = t3;
      cyc++;
    end
    checks++;
    if (recv != 20 || sent != 20 || bq.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got sent=%0d recv=%0d left=%0d want 20 20 0", sent, recv, bq.size());
    end
  endtask

  task automatic test_flush();
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; vec = 32'(i + 1); op = 2'd1; suffix = 1'b0; excl = 1'b0; tag = 4'(i);
      @(negedge clk);
    end
    flush = 1'b1; in_valid = 1'b1; vec = 32'hFF; tag = 4'h9;
    #1;
    checks++; if (r3 !== 1'b0) begin errors++; $display("FAIL flush_full_ready: got %b want 0", r3); end
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL flush_full_valid: got %b want 1", v3); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", v3); end
    checks++; if (r3 !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", r3); end
    in_valid = 1'b1; vec = 32'h14; op = 2'd1; suffix = 1'b0; excl = 1'b0; tag = 4'hA; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL flush_lat1: got %b want 0", v3); end
    @(negedge clk); #1;
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL flush_lat2: got %b want 0", v3); end
    @(negedge clk); #1;
    checks++;
    if (v3 !== 1'b1 || o3 !== 8'hFC || t3 !== 4'hA) begin
      errors++;
      $display("FAIL flush_emerge: got v=%b vec=%h tag=%h want v=1 vec=fc tag=a", v3, o3, t3);
    end
    @(negedge clk); #1;
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL flush_alone: got %b want 0", v3); end
  endtask

  task automatic test_reset_full();
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; vec = 32'(i); tag = 4'(i);
      @(negedge clk);
    end
    in_valid = 1'b0; resetn = 1'b0;
    #1;
    checks++; if (r3 !== 1'b0) begin errors++; $display("FAIL rstfull_pre_ready: got %b want 0", r3); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL rstfull_v3: got %b want 0", v3); end
    checks++; if (r3 !== 1'b1) begin errors++; $display("FAIL rstfull_r3: got %b want 1", r3); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rstfull_v1: got %b want 0", v1); end
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL rstfull_r1: got %b want 1", r1); end
  endtask

  task automatic test_random();
    int          w;
    logic [35:0] ent;
    logic [31:0] e;
    do_flush();
    for (int j = 0; j < 3; j++) sb[j].delete();
    for (int c = 0; c < 4540; c++) begin
      @(negedge clk);
      if (c < 4500) begin
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      vec = $urandom; op = 2'($urandom_range(0, 3));
      suffix = 1'($urandom_range(0, 1)); excl = 1'($urandom_range(0, 1)); tag = 4'($urandom_range(0, 15));
      #1;
      for (int j = 0; j < 3; j++) begin
        w = (j == 0) ? 2 : (j == 1) ? 8 : 32;
        if (vv[j] === 1'b1 && out_ready) begin
          checks++;
          if (sb[j].size() == 0) begin
            errors++;
            $display("FAIL rand_extra[w%0d]: got tag=%h want no output", w, tv[j]);
          end else begin
            ent = sb[j].pop_front();
            if (ov[j] !== ent[31:0] || tv[j] !== ent[35:32]) begin
              errors++;
              $display("FAIL rand_out[w%0d]: got vec=%h tag=%h want vec=%h tag=%h",
                       w, ov[j], tv[j], ent[31:0], ent[35:32]);
            end
          end
        end
        if (in_valid && rv[j] === 1'b1) begin
          e = ref_scan(vec, w, op, suffix, excl);
          sb[j].push_back({tag, e});
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (sb[j].size() != 0) begin
        errors++;
        $display("FAIL rand_drain[%0d]: got %0d pending want 0", j, sb[j].size());
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
